// File: rtl/updn_counter_param.sv
// updn_counter_param: parameterised up/down counter with clamped load, wrap/saturate bounds and sticky ovf/udf.
// Define UPDN_COUNTER_ASSERT_EN to compile the embedded concurrent assertions; leave it undefined for plain RTL.
module updn_counter_param #(
    parameter int WIDTH   = 8,
    parameter int STEP    = 1,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst_,
    input  logic             ld_cnt_,
    input  logic             updn_cnt,
    input  logic             count_enb,
    input  logic             sat_mode,
    input  logic             clr_flags,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             tc,
    output logic             ovf,
    output logic             udf
);

    // All bound arithmetic is done one bit wider so MAX_VAL = 2**WIDTH-1 never truncates.
    localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]   MODULUS  = (WIDTH+1)'(MAX_VAL + 1);
    localparam logic [WIDTH:0]   STEP_EXT = (WIDTH+1)'(STEP);
    localparam logic [WIDTH-1:0] MAX_W    = WIDTH'(MAX_VAL);

    logic [WIDTH:0]   cnt_ext;
    logic [WIDTH:0]   din_ext;
    logic [WIDTH:0]   up_sum;
    logic [WIDTH:0]   up_wrap;
    logic [WIDTH:0]   dn_diff;
    logic [WIDTH:0]   dn_wrap;
    logic             up_cross;
    logic             dn_cross;
    logic [WIDTH-1:0] cnt_nxt;
    logic             ovf_nxt;
    logic             udf_nxt;

    always_comb begin
        cnt_ext  = {1'b0, data_out};
        din_ext  = {1'b0, data_in};
        up_sum   = cnt_ext + STEP_EXT;
        up_wrap  = up_sum - MODULUS;
        dn_diff  = cnt_ext - STEP_EXT;
        dn_wrap  = cnt_ext + MODULUS - STEP_EXT;
        up_cross = (up_sum > MAX_EXT);
        dn_cross = (cnt_ext < STEP_EXT);
    end

    // Load beats count beats hold; a flag set on this edge overrides a simultaneous clear.
    always_comb begin
        cnt_nxt = data_out;
        ovf_nxt = ovf & ~clr_flags;
        udf_nxt = udf & ~clr_flags;
        if (!ld_cnt_) begin
            cnt_nxt = (din_ext > MAX_EXT) ? MAX_W : data_in;
        end else if (count_enb) begin
            if (updn_cnt) begin
                if (up_cross) begin
                    ovf_nxt = 1'b1;
                    cnt_nxt = sat_mode ? MAX_W : WIDTH'(up_wrap);
                end else begin
                    cnt_nxt = WIDTH'(up_sum);
                end
            end else begin
                if (dn_cross) begin
                    udf_nxt = 1'b1;
                    cnt_nxt = sat_mode ? '0 : WIDTH'(dn_wrap);
                end else begin
                    cnt_nxt = WIDTH'(dn_diff);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            data_out <= '0;
            ovf      <= 1'b0;
            udf      <= 1'b0;
        end else begin
            data_out <= cnt_nxt;
            ovf      <= ovf_nxt;
            udf      <= udf_nxt;
        end
    end

    assign tc = ld_cnt_ & count_enb & (updn_cnt ? up_cross : dn_cross);

`ifdef UPDN_COUNTER_ASSERT_EN
    a_reset_clears: assert property (@(posedge clk) disable iff (!rst_)
        $rose(rst_) |-> ($past(data_out) == '0 && !$past(ovf) && !$past(udf)))
        else $error("%0d a_reset_clears failed", $stime);

    a_hold: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && !count_enb && !clr_flags) |=>
        (data_out == $past(data_out) && ovf == $past(ovf) && udf == $past(udf)))
        else $error("%0d a_hold failed", $stime);

    a_up_step: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && count_enb && updn_cnt && !up_cross) |=> (data_out == WIDTH'($past(up_sum))))
        else $error("%0d a_up_step failed", $stime);

    a_down_step: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && count_enb && !updn_cnt && !dn_cross) |=> (data_out == WIDTH'($past(dn_diff))))
        else $error("%0d a_down_step failed", $stime);

    a_up_bound: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && count_enb && updn_cnt && up_cross) |=>
        (ovf && data_out == ($past(sat_mode) ? MAX_W : WIDTH'($past(up_wrap)))))
        else $error("%0d a_up_bound failed", $stime);

    a_down_bound: assert property (@(posedge clk) disable iff (!rst_)
        (ld_cnt_ && count_enb && !updn_cnt && dn_cross) |=>
        (udf && data_out == ($past(sat_mode) ? '0 : WIDTH'($past(dn_wrap)))))
        else $error("%0d a_down_bound failed", $stime);

    a_ovf_sticky: assert property (@(posedge clk) disable iff (!rst_)
        (ovf && !clr_flags) |=> ovf)
        else $error("%0d a_ovf_sticky failed", $stime);

    a_udf_sticky: assert property (@(posedge clk) disable iff (!rst_)
        (udf && !clr_flags) |=> udf)
        else $error("%0d a_udf_sticky failed", $stime);
`endif

endmodule

// File: tb/tb_updn_counter_param.sv
// tb_updn_counter_param: scoreboard bench for updn_counter_param with three builds:
// default 8-bit step 1, 8-bit step 3, and a 4-bit decade counter (MAX_VAL 9).
module tb_updn_counter_param;

    logic       clk       = 1'b0;
    logic       rst_      = 1'b1;
    logic       ld_cnt_   = 1'b1;
    logic       updn_cnt  = 1'b1;
    logic       count_enb = 1'b0;
    logic       sat_mode  = 1'b0;
    logic       clr_flags = 1'b0;
    logic [7:0] data_in   = '0;
    logic [7:0] q_a, q_b;
    logic [3:0] q_c;
    logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c, udf_a, udf_b, udf_c;

    typedef struct {
        int         inst;
        logic [7:0] cnt;
        logic       ovf;
        logic       udf;
        logic       tc;
    } exp_t;

    typedef struct {
        logic       ld_n;
        logic       up;
        logic       en;
        logic       sat;
        logic       clr;
        logic [7:0] din;
        exp_t       e;
    } step_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cnt[3];
    bit   m_ovf[3];
    bit   m_udf[3];

    always #5 clk = ~clk;

    updn_counter_param #(.WIDTH(8), .STEP(1)) dut_a (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .sat_mode(sat_mode), .clr_flags(clr_flags), .data_in(data_in),
        .data_out(q_a), .tc(tc_a), .ovf(ovf_a), .udf(udf_a));

    updn_counter_param #(.WIDTH(8), .STEP(3)) dut_b (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .sat_mode(sat_mode), .clr_flags(clr_flags), .data_in(data_in),
        .data_out(q_b), .tc(tc_b), .ovf(ovf_b), .udf(udf_b));

    updn_counter_param #(.WIDTH(4), .STEP(1), .MAX_VAL(9)) dut_c (
        .clk(clk), .rst_(rst_), .ld_cnt_(ld_cnt_), .updn_cnt(updn_cnt), .count_enb(count_enb),
        .sat_mode(sat_mode), .clr_flags(clr_flags), .data_in(data_in[3:0]),
        .data_out(q_c), .tc(tc_c), .ovf(ovf_c), .udf(udf_c));

    function automatic logic [7:0] act_cnt(input int i);
        case (i)
            0:       return q_a;
            1:       return q_b;
            default: return {4'b0000, q_c};
        endcase
    endfunction

    function automatic logic act_ovf(input int i);
        case (i)
            0:       return ovf_a;
            1:       return ovf_b;
            default: return ovf_c;
        endcase
    endfunction

    function automatic logic act_udf(input int i);
        case (i)
            0:       return udf_a;
            1:       return udf_b;
            default: return udf_c;
        endcase
    endfunction

    function automatic logic act_tc(input int i);
        case (i)
            0:       return tc_a;
            1:       return tc_b;
            default: return tc_c;
        endcase
    endfunction

    function automatic step_t mk(input int inst, input logic ld_n, input logic up, input logic en,
                                 input logic sat, input logic clr, input logic [7:0] din,
                                 input logic [7:0] cnt, input logic ovf, input logic udf, input logic tc);
        step_t s;
        s.ld_n = ld_n; s.up = up; s.en = en; s.sat = sat; s.clr = clr; s.din = din;
        s.e.inst = inst; s.e.cnt = cnt; s.e.ovf = ovf; s.e.udf = udf; s.e.tc = tc;
        return s;
    endfunction

    // Reference behaviour written from the counter's arithmetic definition, using plain integers.
    function automatic exp_t model_step(input int i);
        int   mx, st, din;
        exp_t e;
        mx  = (i == 2) ? 9 : 255;
        st  = (i == 1) ? 3 : 1;
        din = (i == 2) ? int'(data_in[3:0]) : int'(data_in);
        if (clr_flags) begin
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
        if (!ld_cnt_) begin
            m_cnt[i] = (din > mx) ? mx : din;
        end else if (count_enb) begin
            if (updn_cnt) begin
                if (m_cnt[i] + st > mx) begin
                    m_ovf[i] = 1'b1;
                    m_cnt[i] = sat_mode ? mx : m_cnt[i] + st - (mx + 1);
                end else begin
                    m_cnt[i] = m_cnt[i] + st;
                end
            end else begin
                if (m_cnt[i] < st) begin
                    m_udf[i] = 1'b1;
                    m_cnt[i] = sat_mode ? 0 : m_cnt[i] + (mx + 1) - st;
                end else begin
                    m_cnt[i] = m_cnt[i] - st;
                end
            end
        end
        e.inst = i;
        e.cnt  = 8'(m_cnt[i]);
        e.ovf  = m_ovf[i];
        e.udf  = m_udf[i];
        e.tc   = ld_cnt_ && count_enb && (updn_cnt ? (m_cnt[i] + st > mx) : (m_cnt[i] < st));
        return e;
    endfunction

    task automatic drive(input step_t s);
        ld_cnt_   = s.ld_n;
        updn_cnt  = s.up;
        count_enb = s.en;
        sat_mode  = s.sat;
        clr_flags = s.clr;
        data_in   = s.din;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_      = 1'b0;
        ld_cnt_   = 1'b1;
        count_enb = 1'b0;
        clr_flags = 1'b0;
        @(negedge clk);
        rst_ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m_cnt[i] = 0;
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
        end
    endtask

    task automatic test_reset();
        #2 rst_ = 1'b0;
        ld_cnt_ = 1'b1; count_enb = 1'b1; updn_cnt = 1'b0;
        #2;
        n_checks++;
        if ({q_a, q_b, q_c} !== 20'h0) begin
            n_fail++;
            $display("[TB] FAIL reset data_out: got %0h/%0h/%0h, expected 0/0/0", q_a, q_b, q_c);
        end
        n_checks++;
        if ({ovf_a, udf_a, ovf_b, udf_b, ovf_c, udf_c} !== 6'b0) begin
            n_fail++;
            $display("[TB] FAIL reset flags: got %b, expected 000000", {ovf_a, udf_a, ovf_b, udf_b, ovf_c, udf_c});
        end
        n_checks++;
        if ({tc_a, tc_b, tc_c} !== 3'b111) begin
            n_fail++;
            $display("[TB] FAIL reset tc_down: got %b, expected 111", {tc_a, tc_b, tc_c});
        end
        updn_cnt = 1'b1;
        #1;
        n_checks++;
        if ({tc_a, tc_b, tc_c} !== 3'b000) begin
            n_fail++;
            $display("[TB] FAIL reset tc_up: got %b, expected 000", {tc_a, tc_b, tc_c});
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (q_a !== 8'd0) begin
            n_fail++;
            $display("[TB] FAIL reset hold_through_edge: got %0d, expected 0", q_a);
        end
        @(negedge clk);
        count_enb = 1'b0;
        rst_      = 1'b1;
    endtask

    task automatic test_wrap_up();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back(mk(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd254, 8'd254, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   8'd255, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   8'd1,   1'b1, 1'b0, 1'b0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb.push_back(tbl[k].e);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (act_cnt(e.inst) !== e.cnt) begin
                n_fail++;
                $display("[TB] FAIL wrap_up data_out step %0d: got %0d, expected %0d", k, act_cnt(e.inst), e.cnt);
            end
            n_checks++;
            if (act_ovf(e.inst) !== e.ovf || act_udf(e.inst) !== e.udf) begin
                n_fail++;
                $display("[TB] FAIL wrap_up flags step %0d: got ovf=%b udf=%b, expected ovf=%b udf=%b",
                         k, act_ovf(e.inst), act_udf(e.inst), e.ovf, e.udf);
            end
            n_checks++;
            if (act_tc(e.inst) !== e.tc) begin
                n_fail++;
                $display("[TB] FAIL wrap_up tc step %0d: got %b, expected %b", k, act_tc(e.inst), e.tc);
            end
        end
    endtask

    task automatic test_saturate_down();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back(mk(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2,   8'd2,   1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd0,   8'd0,   1'b0, 1'b1, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'd0,   8'd0,   1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8'd254, 8'd254, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   8'd255, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,   8'd255, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1,   8'd1,   1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,   8'd254, 1'b1, 1'b1, 1'b0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb.push_back(tbl[k].e);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (act_cnt(e.inst) !== e.cnt) begin
                n_fail++;
                $display("[TB] FAIL sat_down data_out step %0d: got %0d, expected %0d", k, act_cnt(e.inst), e.cnt);
            end
            n_checks++;
            if (act_ovf(e.inst) !== e.ovf || act_udf(e.inst) !== e.udf) begin
                n_fail++;
                $display("[TB] FAIL sat_down flags step %0d: got ovf=%b udf=%b, expected ovf=%b udf=%b",
                         k, act_ovf(e.inst), act_udf(e.inst), e.ovf, e.udf);
            end
            n_checks++;
            if (act_tc(e.inst) !== e.tc) begin
                n_fail++;
                $display("[TB] FAIL sat_down tc step %0d: got %b, expected %b", k, act_tc(e.inst), e.tc);
            end
        end
    endtask

    task automatic test_decade();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back(mk(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd8,  8'd8, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  8'd9, 1'b0, 1'b0, 1'b1));
        tbl.push_back(mk(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,  8'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd12, 8'd9, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd0,  8'd9, 1'b1, 1'b0, 1'b1));
        tbl.push_back(mk(2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd0, 1'b1, 1'b0, 1'b0));
        tbl.push_back(mk(2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0,  8'd9, 1'b1, 1'b1, 1'b0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb.push_back(tbl[k].e);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (act_cnt(e.inst) !== e.cnt) begin
                n_fail++;
                $display("[TB] FAIL decade data_out step %0d: got %0d, expected %0d", k, act_cnt(e.inst), e.cnt);
            end
            n_checks++;
            if (act_ovf(e.inst) !== e.ovf || act_udf(e.inst) !== e.udf) begin
                n_fail++;
                $display("[TB] FAIL decade flags step %0d: got ovf=%b udf=%b, expected ovf=%b udf=%b",
                         k, act_ovf(e.inst), act_udf(e.inst), e.ovf, e.udf);
            end
            n_checks++;
            if (act_tc(e.inst) !== e.tc) begin
                n_fail++;
                $display("[TB] FAIL decade tc step %0d: got %b, expected %b", k, act_tc(e.inst), e.tc);
            end
        end
    endtask

    task automatic test_hold();
        step_t tbl[$];
        exp_t  e;
        do_reset();
        tbl.push_back(mk(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd255, 1'b0, 1'b0, 1'b0));
        tbl.push_back(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0,   8'd0,   1'b1, 1'b0, 1'b0));
        for (int n = 0; n < 10; n++)
            tbl.push_back(mk(0, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0,
                             8'($urandom_range(0, 255)), 8'd0, 1'b1, 1'b0, 1'b0));
        foreach (tbl[k]) begin
            drive(tbl[k]);
            sb.push_back(tbl[k].e);
            tick();
            e = sb.pop_front();
            n_checks++;
            if (act_cnt(e.inst) !== e.cnt) begin
                n_fail++;
                $display("[TB] FAIL hold data_out step %0d: got %0d, expected %0d", k, act_cnt(e.inst), e.cnt);
            end
            n_checks++;
            if (act_ovf(e.inst) !== e.ovf || act_udf(e.inst) !== e.udf) begin
                n_fail++;
                $display("[TB] FAIL hold flags step %0d: got ovf=%b udf=%b, expected ovf=%b udf=%b",
                         k, act_ovf(e.inst), act_udf(e.inst), e.ovf, e.udf);
            end
        end
    endtask

    task automatic test_reset_midcount();
        exp_t e;
        do_reset();
        drive(mk(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd255, 8'd0, 1'b0, 1'b0, 1'b0));
        tick();
        drive(mk(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0));
        tick();
        tick();
        n_checks++;
        if (q_a !== 8'd1 || ovf_a !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset precondition: got %0d ovf=%b, expected 1 ovf=1", q_a, ovf_a);
        end
        // Reset lands between edges; the outputs must clear before the next posedge arrives.
        #2 rst_ = 1'b0;
        #1;
        n_checks++;
        if (q_a !== 8'd0 || ovf_a !== 1'b0 || udf_a !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset async_clear: got %0d ovf=%b udf=%b, expected 0 ovf=0 udf=0",
                     q_a, ovf_a, udf_a);
        end
        @(negedge clk);
        rst_ = 1'b1;
        e.inst = 0; e.cnt = 8'd1; e.ovf = 1'b0; e.udf = 1'b0; e.tc = 1'b0;
        sb.push_back(e);
        tick();
        e = sb.pop_front();
        n_checks++;
        if (act_cnt(e.inst) !== e.cnt || act_ovf(e.inst) !== e.ovf) begin
            n_fail++;
            $display("[TB] FAIL midreset first_count: got %0d ovf=%b, expected %0d ovf=%b",
                     act_cnt(e.inst), act_ovf(e.inst), e.cnt, e.ovf);
        end
    endtask

    task automatic test_random();
        exp_t e;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            ld_cnt_   = ($urandom_range(0, 7) != 0);
            count_enb = ($urandom_range(0, 3) != 0);
            updn_cnt  = 1'($urandom_range(0, 1));
            sat_mode  = 1'($urandom_range(0, 1));
            clr_flags = ld_cnt_ && ($urandom_range(0, 5) == 0);
            data_in   = 8'($urandom_range(0, 255));
            for (int i = 0; i < 3; i++) sb.push_back(model_step(i));
            tick();
            for (int i = 0; i < 3; i++) begin
                e = sb.pop_front();
                n_checks++;
                if (act_cnt(e.inst) !== e.cnt || act_ovf(e.inst) !== e.ovf ||
                    act_udf(e.inst) !== e.udf || act_tc(e.inst) !== e.tc) begin
                    n_fail++;
                    $display("[TB] FAIL random cycle %0d inst %0d: got cnt=%0d ovf=%b udf=%b tc=%b, expected cnt=%0d ovf=%b udf=%b tc=%b",
                             n, e.inst, act_cnt(e.inst), act_ovf(e.inst), act_udf(e.inst), act_tc(e.inst),
                             e.cnt, e.ovf, e.udf, e.tc);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_saturate_down();
        test_decade();
        test_hold();
        test_reset_midcount();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
